fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Front end of the 5-stage RV32I pipeline: owns the fetch PC and issues instruction-memory reads.
- Loads the IF/DEC pipeline register.
- Consumes the hold/flush/branch/PCnext controls produced by the branching unit and acts on them cycle by cycle.
- At most one outstanding memory request; a one-entry holding buffer absorbs a response that arrives during hold.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
hold  input  1  stall IF/DEC (load-use)
flush  input  1  kill instruction entering/in IF/DEC
branch  input  1  redirect fetch to PCnext
PCnext  input  32  redirect target; bits [1:0] ignored
imem_req  output  1  read request
imem_addr  output  32  read address (= PC_IF)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
PC_IF  output  32  address currently being fetched
PC_DEC  output  32  PC of instruction in IF/DEC
instr_DEC  output  32  instruction in IF/DEC
valid_DEC  output  1  IF/DEC holds a real instruction

Behaviour:
- Reset, asynchronous:
  - PC_IF=RESET_PC, PC_DEC=0, instr_DEC=NOP_INSTR, valid_DEC=0.
  - imem_req=0, state=IDLE, buffer empty.
  - A response arriving after reset is ignored, because rvalid is ignored in IDLE.
- PC_IF[1:0] is always 00. PC increment is +4 modulo 2^32, so 0xFFFF_FFFC wraps to 0.
- imem_addr=PC_IF (combinational).
- States:
  - IDLE: imem_req = !buf_valid || !hold. On req&&gnt go to WAIT; PC_IF is unchanged.
  - WAIT: imem_req=0. On rvalid:
    - hold=1: rdata and PC_IF go into the buffer.
    - hold=0: rdata and PC_IF go into IF/DEC with valid_DEC=1.
    - In both cases PC_IF<=PC_IF+4 and the state returns to IDLE.
  - DISCARD: imem_req=0. On rvalid, drop the data and go to IDLE.
- Branch, overriding hold:
  - PC_IF<=PCnext&~3 and the buffer is cleared.
  - In IDLE with req&&gnt the same cycle, the granted request belongs to the old path, so go to DISCARD.
  - In WAIT without rvalid, go to DISCARD.
  - In WAIT with rvalid the same cycle, drop the data and go to IDLE.
  - In DISCARD, update PC_IF and stay in DISCARD.
- IF/DEC update priority: flush > hold > buffer > fresh response > bubble.
  - flush: valid_DEC<=0, instr_DEC<=NOP_INSTR. PC_DEC is don't-care and holds its value.
  - hold (no flush): PC_DEC, instr_DEC and valid_DEC retain their values.
  - Buffer valid and hold=0: IF/DEC loads from the buffer and the buffer empties. A fresh response cannot coincide, since no request is outstanding while the buffer is full.
  - Fresh response (WAIT, rvalid, hold=0, no branch): IF/DEC loads the response.
  - Otherwise: bubble (valid_DEC<=0, instr_DEC<=NOP_INSTR).
- flush does not change PC_IF or the buffer. The branching unit asserts branch alongside flush for a redirect.
- hold+flush together: flush wins and IF/DEC becomes a bubble.
- imem_gnt is ignored when imem_req=0. imem_rvalid is ignored in IDLE.
- Latency: with zero-wait-state memory (gnt same cycle, rvalid next cycle), a fetch issued at edge n appears in IF/DEC after edge n+2. Throughput is one instruction per 2 cycles.

Test Plan:
1. Reset release, memory with gnt=1 and rvalid one cycle later, data=addr^0xA5A5_0000:
   - imem_addr sequence is 0x0, 0x4, 0x8.
   - IF/DEC shows PC_DEC 0x0 then 0x4 then 0x8 with the matching data and valid_DEC=1.
   - Bubbles appear in between.
2. hold high for 5 cycles, spanning an rvalid for 0x8:
   - IF/DEC stays at 0x4 throughout.
   - The buffer captures 0x8 and imem_req stays 0 while the buffer is full.
   - The cycle after hold falls, PC_DEC=0x8.
3. branch=1 with PCnext=0x100 while in WAIT for 0x10, with rvalid 2 cycles later:
   - The 0x10 data never reaches IF/DEC.
   - The next imem_addr is 0x100.
   - PC_DEC=0x100 is delivered.
4. branch with PCnext=0x203 in the same cycle as req&&gnt for 0x14:
   - The state goes to DISCARD and the 0x14 response is dropped.
   - imem_addr becomes 0x200.
5. flush and hold asserted together with valid_DEC=1:
   - Next cycle valid_DEC=0 and instr_DEC=0x0000_0013.
   - PC_IF is unchanged.
6. nReset pulsed low while in WAIT, with rvalid arriving after release:
   - The response is ignored.
   - The first request after reset is to RESET_PC and valid_DEC=0.
   - PC_IF=0xFFFF_FFFC followed by a fetch gives a next fetch address of 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the RV32I pipeline. It owns the fetch PC, issues
// instruction-memory reads with at most one outstanding request, and loads the
// IF/DEC pipeline register. A one-entry buffer holds a response that returns
// while decode is held, so the data is not lost.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        hold,
  input  logic        flush,
  input  logic        branch,
  input  logic [31:0] PCnext,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] PC_DEC,
  output logic [31:0] instr_DEC,
  output logic        valid_DEC
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] pc_dec_q, pc_dec_d;
  logic [31:0] instr_dec_q, instr_dec_d;
  logic        valid_dec_q, valid_dec_d;

  logic        req_grant;
  logic        fresh_rsp;

  // Request only from IDLE, and never while a held response is still parked
  // in the buffer; the request is also forced low while reset is asserted.
  always_comb begin
    imem_req = nReset && (state_q == IDLE) && (!buf_valid_q || !hold);
  end

  assign imem_addr = pc_q;
  assign PC_IF     = pc_q;
  assign PC_DEC    = pc_dec_q;
  assign instr_DEC = instr_dec_q;
  assign valid_DEC = valid_dec_q;

  assign req_grant = imem_req && imem_gnt;
  // A response that belongs to the current path and may enter IF/DEC.
  assign fresh_rsp = (state_q == WAIT) && imem_rvalid && !branch;

  // Next-state logic: request FSM, fetch PC, holding buffer and IF/DEC.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    pc_dec_d    = pc_dec_q;
    instr_dec_d = instr_dec_q;
    valid_dec_d = valid_dec_q;

    case (state_q)
      IDLE: begin
        // A grant in the same cycle as a redirect fetched the old path.
        if (req_grant) begin
          state_d = branch ? DISCARD : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          if (!branch) begin
            pc_d = pc_q + 32'd4;
            if (hold) begin
              buf_valid_d = 1'b1;
              buf_pc_d    = pc_q;
              buf_instr_d = imem_rdata;
            end
          end
        end else if (branch) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // Swallow the stale response; further redirects just move the PC.
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect overrides the sequential increment and kills the buffer.
    if (branch) begin
      pc_d        = PCnext & 32'hFFFF_FFFC;
      buf_valid_d = 1'b0;
    end

    // IF/DEC priority: flush, hold, buffered response, fresh response, bubble.
    if (flush) begin
      valid_dec_d = 1'b0;
      instr_dec_d = NOP_INSTR;
    end else if (hold) begin
      // keep current contents
    end else if (buf_valid_q) begin
      pc_dec_d    = buf_pc_q;
      instr_dec_d = buf_instr_q;
      valid_dec_d = 1'b1;
      buf_valid_d = 1'b0;
    end else if (fresh_rsp) begin
      pc_dec_d    = pc_q;
      instr_dec_d = imem_rdata;
      valid_dec_d = 1'b1;
    end else begin
      valid_dec_d = 1'b0;
      instr_dec_d = NOP_INSTR;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC & 32'hFFFF_FFFC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= NOP_INSTR;
      pc_dec_q    <= 32'h0;
      instr_dec_q <= NOP_INSTR;
      valid_dec_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      pc_dec_q    <= pc_dec_d;
      instr_dec_q <= instr_dec_d;
      valid_dec_q <= valid_dec_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table drives the control
// and memory inputs, and every row carries hand-computed expected outputs.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        hold = 1'b0, flush = 1'b0, branch = 1'b0;
  logic [31:0] PCnext = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] PC_IF, PC_DEC, instr_DEC;
  logic        valid_DEC;

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .Clock(Clock), .nReset(nReset), .hold(hold), .flush(flush),
    .branch(branch), .PCnext(PCnext), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .PC_IF(PC_IF), .PC_DEC(PC_DEC),
    .instr_DEC(instr_DEC), .valid_DEC(valid_DEC)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic        hold, flush, branch;
    logic [31:0] pcnext;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pcdec, e_instr, e_pcif;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic add(input logic rst, input logic h, input logic f, input logic b,
                     input logic [31:0] pcn, input logic g, input logic rv,
                     input logic [31:0] rd, input logic ereq, input logic [31:0] eaddr,
                     input logic ev, input logic [31:0] epcdec, input logic [31:0] einstr,
                     input logic [31:0] epcif);
    vecs[nvec] = '{rst, h, f, b, pcn, g, rv, rd, ereq, eaddr, ev, epcdec, einstr, epcif};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic f, input logic b, input logic [31:0] pcn,
                       input logic g, input logic rv, input logic [31:0] rd);
    hold = h; flush = f; branch = b; PCnext = pcn;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
  endtask

  initial begin
    // ---- test 1: straight-line fetch, zero-wait memory, data = addr ^ A5A5_0000
    add(1,0,0,0,0, 0,0,0,                 0,32'h0,   0,32'h0,   NOP,          32'h0);
    add(0,0,0,0,0, 1,0,0,                 1,32'h0,   0,0,       NOP,          32'h0);
    add(0,0,0,0,0, 1,1,32'hA5A5_0000,     0,32'h0,   1,32'h0,   32'hA5A5_0000,32'h4);
    add(0,0,0,0,0, 1,0,0,                 1,32'h4,   0,0,       NOP,          32'h4);
    add(0,0,0,0,0, 1,1,32'hA5A5_0004,     0,32'h4,   1,32'h4,   32'hA5A5_0004,32'h8);
    add(0,0,0,0,0, 1,0,0,                 1,32'h8,   0,0,       NOP,          32'h8);
    add(0,0,0,0,0, 1,1,32'hA5A5_0008,     0,32'h8,   1,32'h8,   32'hA5A5_0008,32'hC);
    add(0,0,0,0,0, 0,0,0,                 1,32'hC,   0,0,       NOP,          32'hC);
    // ---- test 2: hold for 5 cycles spanning the 0x8 response
    add(1,0,0,0,0, 0,0,0,                 0,32'h0,   0,32'h0,   NOP,          32'h0);
    add(0,0,0,0,0, 1,0,0,                 1,32'h0,   0,0,       NOP,          32'h0);
    add(0,0,0,0,0, 1,1,32'hA5A5_0000,     0,32'h0,   1,32'h0,   32'hA5A5_0000,32'h4);
    add(0,0,0,0,0, 1,0,0,                 1,32'h4,   0,0,       NOP,          32'h4);
    add(0,0,0,0,0, 1,1,32'hA5A5_0004,     0,32'h4,   1,32'h4,   32'hA5A5_0004,32'h8);
    add(0,1,0,0,0, 1,0,0,                 1,32'h8,   1,32'h4,   32'hA5A5_0004,32'h8);
    add(0,1,0,0,0, 1,1,32'hA5A5_0008,     0,32'h8,   1,32'h4,   32'hA5A5_0004,32'hC);
    add(0,1,0,0,0, 1,0,0,                 0,32'hC,   1,32'h4,   32'hA5A5_0004,32'hC);
    add(0,1,0,0,0, 1,0,0,                 0,32'hC,   1,32'h4,   32'hA5A5_0004,32'hC);
    add(0,1,0,0,0, 1,0,0,                 0,32'hC,   1,32'h4,   32'hA5A5_0004,32'hC);
    add(0,0,0,0,0, 1,0,0,                 1,32'hC,   1,32'h8,   32'hA5A5_0008,32'hC);
    add(0,0,0,0,0, 1,1,32'hA5A5_000C,     0,32'hC,   1,32'hC,   32'hA5A5_000C,32'h10);
    // ---- test 3: redirect to 0x100 while waiting for 0x10
    add(0,0,0,0,0, 1,0,0,                 1,32'h10,  0,0,       NOP,          32'h10);
    add(0,0,1,1,32'h100, 1,0,0,           0,32'h10,  0,0,       NOP,          32'h100);
    add(0,0,0,0,0, 0,1,32'hA5A5_0010,     0,32'h100, 0,0,       NOP,          32'h100);
    add(0,0,0,0,0, 1,0,0,                 1,32'h100, 0,0,       NOP,          32'h100);
    add(0,0,0,0,0, 1,1,32'hA5A5_0100,     0,32'h100, 1,32'h100, 32'hA5A5_0100,32'h104);
    // ---- test 4: redirect to 0x203 in the grant cycle of 0x14
    add(0,0,0,1,32'h14, 0,0,0,            1,32'h104, 0,0,       NOP,          32'h14);
    add(0,0,1,1,32'h203, 1,0,0,           1,32'h14,  0,0,       NOP,          32'h200);
    add(0,0,0,0,0, 1,1,32'hA5A5_0014,     0,32'h200, 0,0,       NOP,          32'h200);
    add(0,0,0,0,0, 1,0,0,                 1,32'h200, 0,0,       NOP,          32'h200);
    add(0,0,0,0,0, 1,1,32'hA5A5_0200,     0,32'h200, 1,32'h200, 32'hA5A5_0200,32'h204);
    // ---- test 5: flush + hold with a valid instruction in IF/DEC
    add(0,1,1,0,0, 0,0,0,                 1,32'h204, 0,0,       NOP,          32'h204);
    // ---- test 6: reset while in WAIT, late response, then PC wrap
    add(0,0,0,0,0, 1,0,0,                 1,32'h204, 0,0,       NOP,          32'h204);
    add(1,0,0,0,0, 0,0,0,                 0,32'h0,   0,32'h0,   NOP,          32'h0);
    add(0,0,0,0,0, 0,1,32'hA5A5_0204,     1,32'h0,   0,0,       NOP,          32'h0);
    add(0,0,0,0,0, 1,0,0,                 1,32'h0,   0,0,       NOP,          32'h0);
    add(0,0,0,0,0, 1,1,32'hA5A5_0000,     0,32'h0,   1,32'h0,   32'hA5A5_0000,32'h4);
    add(0,0,0,1,32'hFFFF_FFFF, 0,0,0,     1,32'h4,   0,0,       NOP,          32'hFFFF_FFFC);
    add(0,0,0,0,0, 1,0,0,                 1,32'hFFFF_FFFC, 0,0, NOP,          32'hFFFF_FFFC);
    add(0,0,0,0,0, 1,1,32'h5A5A_FFFC,     0,32'hFFFF_FFFC, 1,32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0);
    add(0,0,0,0,0, 0,0,0,                 1,32'h0,   0,0,       NOP,          32'h0);

    for (int i = 0; i < nvec; i++) begin
      @(negedge Clock);
      nReset = !vecs[i].rst;
      drive(vecs[i].hold, vecs[i].flush, vecs[i].branch, vecs[i].pcnext,
            vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d valid_DEC", i), {31'b0, valid_DEC}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d instr_DEC", i), instr_DEC, vecs[i].e_instr);
      chk($sformatf("v%0d PC_IF", i), PC_IF, vecs[i].e_pcif);
      if (vecs[i].e_valid || vecs[i].rst)
        chk($sformatf("v%0d PC_DEC", i), PC_DEC, vecs[i].e_pcdec);
      $display("[TB] vec %0d: req=%b addr=%h PC_IF=%h valid=%b PC_DEC=%h instr=%h",
               i, imem_req, imem_addr, PC_IF, valid_DEC, PC_DEC, instr_DEC);
    end

    // ---- hand sequence: second redirect while already discarding
    // Starts in IDLE at PC 0 with an empty buffer.
    @(negedge Clock); drive(0,0,0,32'h0, 1,0,32'h0); #1;
    chk("seq grant req", {31'b0, imem_req}, 32'd1);
    @(negedge Clock); drive(0,0,1,32'h40, 0,0,32'h0); #1;
    chk("seq wait req", {31'b0, imem_req}, 32'd0);
    @(posedge Clock); #1;
    chk("seq redirect1 PC_IF", PC_IF, 32'h40);
    @(negedge Clock); drive(0,0,1,32'h80, 1,0,32'h0); #1;
    chk("seq discard req", {31'b0, imem_req}, 32'd0);
    @(posedge Clock); #1;
    chk("seq redirect2 PC_IF", PC_IF, 32'h80);
    @(negedge Clock); drive(0,0,0,32'h0, 0,1,32'hDEAD_BEEF); #1;
    chk("seq stale req", {31'b0, imem_req}, 32'd0);
    @(posedge Clock); #1;
    chk("seq stale valid_DEC", {31'b0, valid_DEC}, 32'd0);
    chk("seq stale instr_DEC", instr_DEC, NOP);
    @(negedge Clock); drive(0,0,0,32'h0, 0,0,32'h0); #1;
    chk("seq resume req", {31'b0, imem_req}, 32'd1);
    chk("seq resume addr", imem_addr, 32'h80);
    $display("[TB] seq: redirect during DISCARD, PC_IF=%h req=%b", PC_IF, imem_req);

    // ---- hand sequence: asynchronous reset takes effect between edges
    @(negedge Clock); #2;
    nReset = 1'b0; #1;
    chk("async rst PC_IF", PC_IF, 32'h0);
    chk("async rst req", {31'b0, imem_req}, 32'd0);
    @(negedge Clock); nReset = 1'b1;
    $display("[TB] seq: async reset, PC_IF=%h req=%b", PC_IF, imem_req);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
